// File: rtl/serial_tx_leds.sv
// Bit-serial transmitter: a switch word is shifted out LSB-first and looped back on the LEDs.
// Each word bit is sent on a step key press or on a fixed tick; two hex digits show the bit count and the state.
module hex2seven_seg (
    input  logic [3:0] value,
    output logic [6:0] seg
);
    // Active-low segments, bit order gfedcba
    always_comb begin
        unique case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end
endmodule

module serial_tx_leds #(
    parameter int DATA_W   = 8,
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] switches,
    input  logic       auto_mode,
    input  logic       load_button,
    input  logic       start_button,
    input  logic       step_button,
    output logic       serial_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] LEDS_R,
    output logic [7:0] LEDS_G,
    output logic [6:0] hex1,
    output logic [6:0] hex2
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);
    localparam logic [3:0] ALL_BITS = 4'(DATA_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SEND   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, state_next;
    logic [7:0] held, held_next;
    logic [7:0] shreg, shreg_next;
    logic [7:0] leds_g, leds_g_next;
    logic [3:0] bit_cnt, bit_cnt_next;
    logic [TW-1:0] tick_cnt, tick_cnt_next;
    logic serial_next;
    logic step_event;

    // Key samplers: no reset, a push is the first clk the sampled level is high
    logic [2:0] key_r, key_rr, push;
    always_ff @(posedge clk) begin
        key_r  <= {step_button, start_button, load_button};
        key_rr <= key_r;
    end
    assign push = key_r & ~key_rr;

    always_comb begin
        state_next    = state;
        held_next     = held;
        shreg_next    = shreg;
        leds_g_next   = leds_g;
        bit_cnt_next  = bit_cnt;
        tick_cnt_next = '0;
        serial_next   = 1'b0;
        step_event    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (push[0]) begin
                    held_next    = switches;
                    shreg_next   = switches;
                    leds_g_next  = '0;
                    bit_cnt_next = '0;
                    state_next   = LOADED;
                end else if (push[1] && state == DONE) begin
                    shreg_next   = held;
                    leds_g_next  = '0;
                    bit_cnt_next = '0;
                    serial_next  = held[0];
                    state_next   = SEND;
                end
            end
            LOADED: begin
                if (push[0]) begin
                    held_next  = switches;
                    shreg_next = switches;
                end else if (push[1]) begin
                    leds_g_next  = '0;
                    bit_cnt_next = '0;
                    serial_next  = shreg[0];
                    state_next   = SEND;
                end
            end
            SEND: begin
                serial_next = serial_out;
                if (auto_mode) begin
                    step_event    = (tick_cnt == TICK_MAX);
                    tick_cnt_next = step_event ? '0 : tick_cnt + 1'b1;
                end else begin
                    step_event = push[2];
                end
                if (step_event) begin
                    leds_g_next  = {shreg[0], leds_g[7:1]};
                    shreg_next   = {1'b0, shreg[7:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    serial_next  = shreg[1];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = ALL_BITS;
                        serial_next  = 1'b0;
                        state_next   = DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            held       <= '0;
            shreg      <= '0;
            leds_g     <= '0;
            bit_cnt    <= '0;
            tick_cnt   <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            held       <= held_next;
            shreg      <= shreg_next;
            leds_g     <= leds_g_next;
            bit_cnt    <= bit_cnt_next;
            tick_cnt   <= tick_cnt_next;
            serial_out <= serial_next;
            busy       <= (state_next == SEND);
            done       <= (state_next == DONE);
        end
    end

    assign LEDS_R = shreg;
    assign LEDS_G = leds_g;

    hex2seven_seg u_hex_cnt (
        .value(bit_cnt),
        .seg  (hex1)
    );

    hex2seven_seg u_hex_state (
        .value({2'b00, state}),
        .seg  (hex2)
    );
endmodule

// File: tb/tb_serial_tx_leds.sv
// Directed bench for serial_tx_leds with a short auto-mode bit period.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_tx_leds;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] switches = '0;
    logic auto_mode = 1'b0;
    logic load_button = 1'b0;
    logic start_button = 1'b0;
    logic step_button = 1'b0;
    logic serial_out, busy, done;
    logic [7:0] LEDS_R, LEDS_G;
    logic [6:0] hex1, hex2;

    int checks = 0;
    int errors = 0;

    // Active-low gfedcba digit patterns
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};
    // A5 sent LSB-first
    logic bits_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic bits_3c [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic [7:0] rem_a5 [9] = '{8'hA5, 8'h52, 8'h29, 8'h14, 8'h0A,
                               8'h05, 8'h02, 8'h01, 8'h00};

    serial_tx_leds #(.DATA_W(8), .TICK_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .switches    (switches),
        .auto_mode   (auto_mode),
        .load_button (load_button),
        .start_button(start_button),
        .step_button (step_button),
        .serial_out  (serial_out),
        .busy        (busy),
        .done        (done),
        .LEDS_R      (LEDS_R),
        .LEDS_G      (LEDS_G),
        .hex1        (hex1),
        .hex2        (hex2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // which: 0 load, 1 start, 2 step, 3 load+start together
    task automatic push(input int which);
        load_button  = (which == 0 || which == 3);
        start_button = (which == 1 || which == 3);
        step_button  = (which == 2);
        repeat (2) @(negedge clk);
        load_button  = 1'b0;
        start_button = 1'b0;
        step_button  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Returns at the first falling edge with SEND entered
    task automatic start_sync();
        start_button = 1'b1;
        repeat (2) @(negedge clk);
        start_button = 1'b0;
    endtask

    task automatic manual_frame(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_bit"}, serial_out, bits_a5[i]);
            push(2);
            chk({tag, "_rem"}, LEDS_R, rem_a5[i+1]);
        end
        chk({tag, "_g"}, LEDS_G, 8'hA5);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_ser0"}, serial_out, 1'b0);
    endtask

    initial begin
        // 1: reset with keys toggling
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            load_button  = i[0];
            start_button = ~i[0];
            step_button  = i[0];
            @(negedge clk);
        end
        load_button = 1'b0;
        start_button = 1'b0;
        step_button = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", {serial_out, busy, done}, 3'b000);
        chk("rst_leds", {LEDS_R, LEDS_G}, 16'h0000);
        chk("rst_hex2", hex2, seg_tbl[0]);
        chk("rst_hex1", hex1, seg_tbl[0]);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold", hex2, seg_tbl[0]);
        push(1);
        push(2);
        chk("idle_ign", {hex2, busy}, {seg_tbl[0], 1'b0});

        // 2: manual frame of A5
        switches = 8'hA5;
        push(0);
        chk("ld_state", hex2, seg_tbl[1]);
        chk("ld_r", LEDS_R, 8'hA5);
        chk("ld_ser", serial_out, 1'b0);
        push(1);
        chk("snd_state", hex2, seg_tbl[2]);
        chk("snd_busy", busy, 1'b1);
        manual_frame("man");
        chk("man_cnt", hex1, seg_tbl[8]);
        chk("man_state", hex2, seg_tbl[3]);

        // 4: load/start ignored in SEND, then resend from DONE
        push(0);
        push(1);
        for (int i = 0; i < 3; i++) push(2);
        switches = 8'hFF;
        push(0);
        push(1);
        chk("ign_r", LEDS_R, 8'h14);
        chk("ign_busy", busy, 1'b1);
        chk("ign_cnt", hex1, seg_tbl[3]);
        for (int i = 3; i < 8; i++) push(2);
        chk("ign_g", LEDS_G, 8'hA5);
        chk("ign_done", done, 1'b1);
        push(1);
        chk("rs_busy", busy, 1'b1);
        chk("rs_g0", LEDS_G, 8'h00);
        manual_frame("rs");

        // 5: load and start in the same clk while LOADED
        switches = 8'h5A;
        push(0);
        switches = 8'hC3;
        push(3);
        chk("ls_state", hex2, seg_tbl[1]);
        chk("ls_r", LEDS_R, 8'hC3);
        chk("ls_busy", busy, 1'b0);
        push(1);
        chk("ls_send", busy, 1'b1);
        chk("ls_ser", serial_out, 1'b1);
        for (int i = 0; i < 8; i++) push(2);
        chk("ls_g", LEDS_G, 8'hC3);

        // 3: auto mode frame of 3C
        auto_mode = 1'b1;
        switches = 8'h3C;
        push(0);
        start_sync();
        for (int k = 0; k < 32; k++) begin
            chk("auto_bit", serial_out, bits_3c[k/4]);
            chk("auto_busy", busy, 1'b1);
            @(negedge clk);
        end
        chk("auto_done", done, 1'b1);
        chk("auto_g", LEDS_G, 8'h3C);
        chk("auto_r", LEDS_R, 8'h00);

        // 6: reset after 5 auto bits
        switches = 8'hA5;
        push(0);
        start_sync();
        repeat (20) @(negedge clk);
        chk("mid_r", LEDS_R, 8'h05);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_state", hex2, seg_tbl[0]);
        chk("mr_out", {serial_out, busy, done}, 3'b000);
        chk("mr_leds", {LEDS_R, LEDS_G}, 16'h0000);
        reset = 1'b1;
        switches = 8'h81;
        push(0);
        start_sync();
        for (int k = 0; k < 5; k++) begin
            chk("mr_tick", serial_out, (k < 4) ? 1'b1 : 1'b0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
